// File: rtl/vend_sequencer.sv
// Vending sequencer: selection -> stock check -> coin collection -> dispense/refund.
// Optional feature: define VEND_CHANGE_EN to return overpayment as change after a dispense;
// left undefined, overpayment is forfeited on dispense.
module vend_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CREDIT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          index,
  input  logic                index_valid,
  input  logic                cancel,
  output logic                stock_query,
  input  logic                stock_valid,
  input  logic                stock_ok,
  input  logic [CREDIT_W-1:0] price,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  output logic                dispense_req,
  input  logic                dispense_ack,
  output logic [3:0]          sel_index,
  output logic                refund_req,
  output logic [CREDIT_W-1:0] refund_amt,
  input  logic                refund_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                out_of_stock,
  output logic [2:0]          state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_PAY      = 3'd2,
    S_DISPENSE = 3'd3,
    S_REFUND   = 3'd4
  } st_t;

  st_t                 st;
  logic [CREDIT_W-1:0] price_q;
  logic [CNT_W-1:0]    cnt;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                timeout;

  assign state = st;

  // Credit after this cycle's coin, saturating at all-ones; timeout fires as the counter reaches 0
  always_comb begin
    sum        = {1'b0, credit} + {1'b0, coin_value};
    credit_nxt = credit;
    if (coin_valid)
      credit_nxt = sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
    timeout = !coin_valid && (cnt == CNT_W'(1));
  end

  // Main sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      price_q      <= '0;
      cnt          <= CNT_LOAD;
      credit       <= '0;
      sel_index    <= '0;
      refund_amt   <= '0;
      refund_req   <= 1'b0;
      dispense_req <= 1'b0;
      stock_query  <= 1'b0;
      out_of_stock <= 1'b0;
    end else begin
      stock_query  <= 1'b0;
      out_of_stock <= 1'b0;
      case (st)
        S_IDLE: begin
          cnt <= CNT_LOAD;
          if (index_valid) begin
            sel_index   <= index;
            stock_query <= 1'b1;
            st          <= S_CHECK;
          end
        end
        S_CHECK: begin
          // No credit can exist yet, so cancel simply abandons the selection
          if (cancel) begin
            st <= S_IDLE;
          end else if (stock_valid) begin
            if (stock_ok) begin
              price_q <= price;
              cnt     <= CNT_LOAD;
              st      <= S_PAY;
            end else begin
              out_of_stock <= 1'b1;
              st           <= S_IDLE;
            end
          end
        end
        S_PAY: begin
          credit <= credit_nxt;
          cnt    <= coin_valid ? CNT_LOAD : cnt - CNT_W'(1);
          // Cancel/timeout outrank the price compare; a same-cycle coin is included in the refund
          if (cancel || timeout) begin
            cnt <= CNT_LOAD;
            if (credit_nxt == '0) begin
              st <= S_IDLE;
            end else begin
              refund_amt <= credit_nxt;
              refund_req <= 1'b1;
              st         <= S_REFUND;
            end
          end else if (credit >= price_q) begin
            dispense_req <= 1'b1;
            st           <= S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          if (dispense_ack) begin
            dispense_req <= 1'b0;
`ifdef VEND_CHANGE_EN
            if (credit > price_q) begin
              credit     <= credit - price_q;
              refund_amt <= credit - price_q;
              refund_req <= 1'b1;
              st         <= S_REFUND;
            end else begin
              credit <= '0;
              st     <= S_IDLE;
            end
`else
            credit <= '0;
            st     <= S_IDLE;
`endif
          end
        end
        S_REFUND: begin
          if (refund_ack) begin
            refund_req <= 1'b0;
            refund_amt <= '0;
            credit     <= '0;
            st         <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, PAY-state idle cycles before auto-cancel (min 2).
REQ-002 Parameter CREDIT_W, default 8, width of credit/price/coin/refund values.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 index  input  4  product selection.
REQ-006 index_valid  input  1  selection strobe, one cycle.
REQ-007 cancel  input  1  user cancel, level-sampled each cycle.
REQ-008 stock_query  output  1  one-cycle request to inventory for sel_index.
REQ-009 stock_valid  input  1  inventory response strobe.
REQ-010 stock_ok  input  1  item in stock, qualified by stock_valid.
REQ-011 price  input  CREDIT_W  item price, qualified by stock_valid.
REQ-012 coin_valid  input  1  coin strobe.
REQ-013 coin_value  input  CREDIT_W  coin value, qualified by coin_valid.
REQ-014 dispense_req  output  1  dispense handshake request.
REQ-015 dispense_ack  input  1  dispenser done.
REQ-016 sel_index  output  4  latched selection.
REQ-017 refund_req  output  1  refund/change handshake request.
REQ-018 refund_amt  output  CREDIT_W  amount to return; stable while refund_req high.
REQ-019 refund_ack  input  1  coin return done.
REQ-020 credit  output  CREDIT_W  accumulated credit.
REQ-021 out_of_stock  output  1  one-cycle pulse on stock_ok=0.
REQ-022 state  output  3  IDLE=0, CHECK=1, PAY=2, DISPENSE=3, REFUND=4.

Function
REQ-023 IDLE: index_valid latches sel_index, pulses stock_query next cycle, goes CHECK; index_valid ignored in all other states.
REQ-024 CHECK: waits for stock_valid; stock_ok=1 latches price, goes PAY; stock_ok=0 pulses out_of_stock, goes IDLE; cancel goes IDLE (credit is 0).
REQ-025 PAY: coin_valid adds coin_value to credit, saturating at 2^CREDIT_W-1; timeout counter loads TIMEOUT_CYCLES on PAY entry and on each coin, decrements otherwise.
REQ-026 PAY: registered credit >= latched price goes DISPENSE next cycle (1-cycle latency from coin to decision).
REQ-027 PAY: cancel or counter reaching 0 goes REFUND with refund_amt=credit; if credit=0, goes IDLE directly.
REQ-028 PAY: coin_valid with cancel in same cycle: coin added, refund includes it; cancel beats credit>=price evaluated that cycle.
REQ-029 DISPENSE: dispense_req high from entry until dispense_ack sampled; cancel ignored; on ack dispense_req drops same edge.
REQ-030 REFUND: refund_req and refund_amt held until refund_ack; on ack credit, refund_amt cleared, goes IDLE.
REQ-031 No input other than rst_n aborts an open dispense or refund handshake.
REQ-032 Ack received without a matching request is ignored.

Reset
REQ-033 rst_n low asynchronously forces state=IDLE, credit=0, sel_index=0, refund_amt=0, all request/pulse outputs 0, counter=TIMEOUT_CYCLES.
REQ-034 Reset mid-handshake drops requests immediately; collected credit is discarded without refund.

Configuration
REQ-035 Macro VEND_CHANGE_EN defined: on dispense_ack, credit-price>0 goes REFUND with refund_amt=credit-price, else IDLE.
REQ-036 VEND_CHANGE_EN undefined: on dispense_ack, credit cleared, goes IDLE; overpayment forfeited; cancel/timeout refunds unchanged.

Verification
REQ-037 index=5, stock_ok=1, price=50, coins 25,25 -> DISPENSE one cycle after second coin, sel_index=5, credit 0 after ack, IDLE.
REQ-038 price=30, coin 50, VEND_CHANGE_EN -> REFUND refund_amt=20 after dispense_ack; without macro -> IDLE, no refund_req.
REQ-039 price=50, coin 20, no activity TIMEOUT_CYCLES cycles -> REFUND refund_amt=20, IDLE after refund_ack.
REQ-040 stock_ok=0 -> single out_of_stock pulse, IDLE, no dispense_req; index_valid during CHECK ignored.
REQ-041 price=40, credit 20, coin 20 with cancel same cycle -> REFUND refund_amt=40, no dispense_req.
REQ-042 rst_n low while dispense_req high -> dispense_req, credit 0 asynchronously, state IDLE, outputs stay reset until rst_n high.
